// File: rtl/work_receiver_pkg.sv
// work_rx_pkg: shared constants, byte-FSM state type and bit-period helper
// for the getwork serial receiver (work_receiver / uart_rx_byte).
package work_rx_pkg;

  localparam int unsigned WORK_BYTES_C = 84;
  localparam int unsigned WORK_BITS_C  = WORK_BYTES_C * 8;

  // state | meaning
  // IDLE  | line idle, waiting for a low level (candidate start bit)
  // START | timing half a bit to re-check the start bit in its centre
  // DATA  | sampling 8 data bits LSB first, one per bit period
  // STOP  | sampling the stop bit one bit period after the last data bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Clock cycles per serial bit; integer division truncates.
  function automatic int unsigned calc_bit_cycles(input int unsigned freq_hz,
                                                  input int unsigned baud);
    return freq_hz / baud;
  endfunction

endpackage

// File: rtl/work_receiver_if.sv
// work_rx_if: packet-side bundle of the getwork receiver.
//   rx_data   : last complete packet (first byte in the top 8 bits)
//   rx_done   : one-cycle strobe when rx_data is updated
//   frame_err : one-cycle strobe on a bad stop bit
//   rx_busy   : byte in progress or packet partially received
// master = receiver side (drives), slave = miner core side (observes).
interface work_rx_if #(
  parameter int unsigned W = work_rx_pkg::WORK_BITS_C
);
  logic [W-1:0] rx_data;
  logic         rx_done;
  logic         frame_err;
  logic         rx_busy;

  modport master (output rx_data, rx_done, frame_err, rx_busy);
  modport slave  (input  rx_data, rx_done, frame_err, rx_busy);
endinterface

// File: rtl/work_receiver_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver. Two-flop synchronizer on rxd_i, then a
// byte FSM that centres on the start bit and samples each later bit one bit
// period apart.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   rxd_i          : asynchronous serial line, idle high
//   byte_out_o     : last good byte (valid with byte_valid_o)
//   byte_valid_o   : one-cycle pulse, good stop bit seen
//   byte_ferr_o    : one-cycle pulse, stop bit was low
//   active_o       : FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for synchronized line low
// START | half-bit wait, then confirm start (low) or drop glitch (high)
// DATA  | 8 samples, one per bit period, LSB first
// STOP  | one bit period, then accept (high) or flag framing error (low)
module uart_rx_byte
  import work_rx_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 100_000_000,
  parameter int unsigned baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd_i,
  output logic [7:0] byte_out_o,
  output logic       byte_valid_o,
  output logic       byte_ferr_o,
  output logic       active_o
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(comm_clk_frequency, baud_rate);
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int          TW         = $clog2(BIT_CYCLES + 1);

  logic          meta_q, sync_q;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      state_q  <= IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      meta_q   <= rxd_i;
      sync_q   <= meta_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  // Bit timer is a down-counter; every sample happens at terminal count.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync_q) begin
          state_d = START;
          timer_d = TW'(HALF - 1);
        end
      end
      START: begin
        if (timer_q == '0) begin
          if (!sync_q) begin
            state_d  = DATA;
            timer_d  = TW'(BIT_CYCLES - 1);
            bitcnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d  = {sync_q, shift_q[7:1]};
          timer_d  = TW'(BIT_CYCLES - 1);
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          // Straight back to IDLE so a back-to-back start bit is caught.
          state_d = IDLE;
          if (sync_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_out_o   = byte_q;
  assign byte_valid_o = valid_q;
  assign byte_ferr_o  = ferr_q;
  assign active_o     = (state_q != IDLE);

endmodule

// File: rtl/work_receiver.sv
// work_receiver: assembles WORK_BYTES serial bytes into one getwork packet.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   RxD          : asynchronous serial line, idle high
//   wrk          : work_rx_if master (rx_data, rx_done, frame_err, rx_busy)
// Optional: define RX_TIMEOUT_EN to drop a partial packet after
// RX_TIMEOUT_BITS idle bit periods without a start bit.
module work_receiver
  import work_rx_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 100_000_000,
  parameter int unsigned baud_rate          = 115_200,
  parameter int unsigned WORK_BYTES         = WORK_BYTES_C,
  parameter int unsigned RX_TIMEOUT_BITS    = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RxD,
  work_rx_if.master  wrk
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(comm_clk_frequency, baud_rate);
  localparam int          WB         = WORK_BYTES * 8;
  localparam int          CW         = $clog2(WORK_BYTES + 1);

  logic [7:0] byte_out;
  logic       byte_valid, byte_ferr, rx_active;

  uart_rx_byte #(
    .comm_clk_frequency (comm_clk_frequency),
    .baud_rate          (baud_rate)
  ) u_rx_byte (
    .clk          (clk),
    .reset_n      (reset_n),
    .rxd_i        (RxD),
    .byte_out_o   (byte_out),
    .byte_valid_o (byte_valid),
    .byte_ferr_o  (byte_ferr),
    .active_o     (rx_active)
  );

  logic [WB-1:0] asm_q, asm_d;
  logic [WB-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TMO_CYCLES = RX_TIMEOUT_BITS * BIT_CYCLES;
  localparam int          TMW        = $clog2(TMO_CYCLES + 1);
  logic [TMW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (!reset_n) tmo_q <= TMW'(TMO_CYCLES - 1);
    else          tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (RX_TIMEOUT_BITS == 0) || (BIT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      asm_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Only the count marks what is valid in asm_q: clearing it discards the
  // partial packet, since a full packet shifts every old byte out.
  always_comb begin
    asm_d  = asm_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
`ifdef RX_TIMEOUT_EN
    tmo_d  = tmo_q;
`endif
    if (byte_ferr) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      asm_d = {asm_q[WB-9:0], byte_out};
      if (cnt_q == CW'(WORK_BYTES - 1)) begin
        data_d = asm_d;
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef RX_TIMEOUT_EN
    // Idle counter only runs in IDLE with a partial packet held; any start
    // bit (FSM leaves IDLE) reloads it.
    if (rx_active || (cnt_q == '0)) begin
      tmo_d = TMW'(TMO_CYCLES - 1);
    end else if (tmo_q == '0) begin
      cnt_d = '0;
      tmo_d = TMW'(TMO_CYCLES - 1);
    end else begin
      tmo_d = tmo_q - 1'b1;
    end
`endif
  end

  assign wrk.rx_data   = data_q;
  assign wrk.rx_done   = done_q;
  assign wrk.frame_err = byte_ferr;
  assign wrk.rx_busy   = rx_active || (cnt_q != '0);

endmodule

// File: tb/tb_work_receiver.sv
`timescale 1ns/1ps
module tb_work_receiver;

  localparam int PKT_BYTES = 84;
  localparam int PKT_BITS  = 672;
  localparam int BITC      = 8;     // 1 MHz / 115200
  localparam int TMO_CYC   = 100 * BITC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;

  always #5 clk = ~clk;

  work_rx_if wif ();

  work_receiver #(
    .comm_clk_frequency (1_000_000),
    .baud_rate          (115_200),
    .WORK_BYTES         (84),
    .RX_TIMEOUT_BITS    (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .RxD     (rxd),
    .wrk     (wif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: bytes accepted so far, and packets that must appear.
  logic [7:0]          mq[$];
  logic [PKT_BITS-1:0] exp_pkts[$];
  int                  exp_ferr = 0;

  // Observations taken on the falling edge.
  logic [PKT_BITS-1:0] got_pkts[$];
  longint              done_cyc[$];
  int                  ferr_cnt = 0;
  int                  stray = 0;
  longint              cyc = 0;
  logic [PKT_BITS-1:0] prev_data = '0;
  logic                rst_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (wif.rx_done) begin
      got_pkts.push_back(wif.rx_data);
      done_cyc.push_back(cyc);
    end
    if (wif.frame_err) ferr_cnt++;
    if (reset_n && rst_prev && !wif.rx_done && (wif.rx_data !== prev_data)) stray++;
    prev_data = wif.rx_data;
    rst_prev  = reset_n;
  end

  task automatic model_byte(input logic [7:0] b);
    logic [PKT_BITS-1:0] pkt;
    mq.push_back(b);
    if (mq.size() == PKT_BYTES) begin
      pkt = '0;
      for (int i = 0; i < PKT_BYTES; i++) pkt[PKT_BITS-1-8*i -: 8] = mq[i];
      exp_pkts.push_back(pkt);
      mq.delete();
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    wait_cyc(n);
`ifdef RX_TIMEOUT_EN
    if (n > TMO_CYC + 20) mq.delete();
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    rxd = 1'b0;
    wait_cyc(BITC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(BITC);
    end
    rxd = good_stop;
    wait_cyc(BITC);
    if (good_stop) begin
      model_byte(b);
    end else begin
      mq.delete();
      exp_ferr++;
      idle(2 * BITC);
    end
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rxd = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;
    mq.delete();
    wait_cyc(5);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++; if (wif.rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %0h want 0", wif.rx_data); end
    checks++; if (wif.rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", wif.rx_done); end
    checks++; if (wif.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", wif.frame_err); end
    checks++; if (wif.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b want 0", wif.rx_busy); end
    reset_n = 1'b1;
    idle(10);
  endtask

  task automatic test_full_packet();
    logic [7:0] head[8] = '{8'h00, 8'h00, 8'h07, 8'hff, 8'h00, 8'h00, 8'h31, 8'h8e};
    logic [7:0] tail[4] = '{8'h01, 8'h00, 8'h00, 8'h00};
    int g0 = got_pkts.size();
    int e0 = exp_pkts.size();
    for (int i = 0; i < 8; i++) send_byte(head[i], 1'b1);
    send_random(PKT_BYTES - 12);
    for (int i = 0; i < 4; i++) send_byte(tail[i], 1'b1);
    idle(10);
    checks++; if (got_pkts.size() - g0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", got_pkts.size() - g0); end
    if (got_pkts.size() > g0 && exp_pkts.size() > e0) begin
      checks++; if (got_pkts[g0] !== exp_pkts[e0]) begin errors++; $display("FAIL full_data: got %0h want %0h", got_pkts[g0], exp_pkts[e0]); end
    end
    checks++; if (wif.rx_data[PKT_BITS-1 -: 64] !== 64'h000007ff0000318e) begin errors++; $display("FAIL full_head: got %0h want 000007ff0000318e", wif.rx_data[PKT_BITS-1 -: 64]); end
    checks++; if (wif.rx_data[31:0] !== 32'h01000000) begin errors++; $display("FAIL full_tail: got %0h want 01000000", wif.rx_data[31:0]); end
    checks++; if (wif.rx_busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b want 0", wif.rx_busy); end
  endtask

  task automatic test_frame_error();
    int g0, e0;
    do_reset();
    g0 = got_pkts.size();
    e0 = exp_pkts.size();
    send_random(9);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    idle(10);
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL ferr_count: got %0d want %0d", ferr_cnt, exp_ferr); end
    checks++; if (got_pkts.size() !== g0) begin errors++; $display("FAIL ferr_no_done: got %0d want %0d", got_pkts.size(), g0); end
    checks++; if (wif.rx_data !== '0) begin errors++; $display("FAIL ferr_rx_data: got %0h want 0", wif.rx_data); end
    checks++; if (wif.rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b want 0", wif.rx_busy); end
    send_random(PKT_BYTES);
    idle(10);
    checks++; if (got_pkts.size() - g0 !== exp_pkts.size() - e0) begin errors++; $display("FAIL ferr_recover_count: got %0d want %0d", got_pkts.size() - g0, exp_pkts.size() - e0); end
    if (got_pkts.size() > g0 && exp_pkts.size() > e0) begin
      checks++; if (got_pkts[g0] !== exp_pkts[e0]) begin errors++; $display("FAIL ferr_recover_data: got %0h want %0h", got_pkts[g0], exp_pkts[e0]); end
    end
  endtask

  task automatic test_glitch();
    int g0 = got_pkts.size();
    int e0 = exp_pkts.size();
    int f0 = ferr_cnt;
    rxd = 1'b0;
    wait_cyc(2);
    idle(3 * BITC);
    checks++; if (wif.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", wif.rx_busy); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL glitch_ferr: got %0d want %0d", ferr_cnt, f0); end
    send_random(PKT_BYTES);
    idle(10);
    checks++; if (got_pkts.size() - g0 !== 1) begin errors++; $display("FAIL glitch_done_count: got %0d want 1", got_pkts.size() - g0); end
    if (got_pkts.size() > g0 && exp_pkts.size() > e0) begin
      checks++; if (got_pkts[g0] !== exp_pkts[e0]) begin errors++; $display("FAIL glitch_data: got %0h want %0h", got_pkts[g0], exp_pkts[e0]); end
    end
  endtask

  task automatic test_timeout();
    int g0 = got_pkts.size();
    int e0 = exp_pkts.size();
    send_random(40);
    idle(900);
    for (int i = 0; i < PKT_BYTES; i++) send_byte(8'hA5, 1'b1);
    idle(10);
    checks++; if (got_pkts.size() - g0 !== exp_pkts.size() - e0) begin errors++; $display("FAIL tmo_done_count: got %0d want %0d", got_pkts.size() - g0, exp_pkts.size() - e0); end
    if (got_pkts.size() > g0 && exp_pkts.size() > e0) begin
      checks++; if (got_pkts[g0] !== exp_pkts[e0]) begin errors++; $display("FAIL tmo_data: got %0h want %0h", got_pkts[g0], exp_pkts[e0]); end
    end
    checks++; if (wif.rx_busy !== (mq.size() != 0)) begin errors++; $display("FAIL tmo_busy: got %b want %b", wif.rx_busy, (mq.size() != 0)); end
  endtask

  task automatic test_reset_mid_byte();
    int g0, e0;
    logic [7:0] b;
    send_random(19);
    b = 8'($urandom_range(0, 255));
    rxd = 1'b0;
    wait_cyc(BITC);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      wait_cyc(BITC);
    end
    rxd = b[3];
    wait_cyc(BITC / 2);
    reset_n = 1'b0;
    wait_cyc(1);
    checks++; if (wif.rx_data !== '0) begin errors++; $display("FAIL midrst_rx_data: got %0h want 0", wif.rx_data); end
    checks++; if (wif.rx_done !== 1'b0) begin errors++; $display("FAIL midrst_rx_done: got %b want 0", wif.rx_done); end
    checks++; if (wif.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b want 0", wif.frame_err); end
    checks++; if (wif.rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_rx_busy: got %b want 0", wif.rx_busy); end
    reset_n = 1'b1;
    mq.delete();
    idle(20 * BITC);
    g0 = got_pkts.size();
    e0 = exp_pkts.size();
    send_random(PKT_BYTES);
    idle(10);
    checks++; if (got_pkts.size() - g0 !== 1) begin errors++; $display("FAIL midrst_done_count: got %0d want 1", got_pkts.size() - g0); end
    if (got_pkts.size() > g0 && exp_pkts.size() > e0) begin
      checks++; if (got_pkts[g0] !== exp_pkts[e0]) begin errors++; $display("FAIL midrst_data: got %0h want %0h", got_pkts[g0], exp_pkts[e0]); end
    end
  endtask

  task automatic test_back_to_back();
    int g0 = got_pkts.size();
    int e0 = exp_pkts.size();
    int s0 = stray;
    send_random(2 * PKT_BYTES);
    idle(10);
    checks++; if (got_pkts.size() - g0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", got_pkts.size() - g0); end
    for (int i = 0; i < 2; i++) begin
      if (got_pkts.size() > g0 + i && exp_pkts.size() > e0 + i) begin
        checks++; if (got_pkts[g0+i] !== exp_pkts[e0+i]) begin errors++; $display("FAIL b2b_data%0d: got %0h want %0h", i, got_pkts[g0+i], exp_pkts[e0+i]); end
      end
    end
    if (done_cyc.size() >= g0 + 2) begin
      checks++; if (done_cyc[g0+1] - done_cyc[g0] !== longint'(PKT_BYTES * 10 * BITC)) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", done_cyc[g0+1] - done_cyc[g0], PKT_BYTES * 10 * BITC); end
    end
    checks++; if (stray !== s0) begin errors++; $display("FAIL b2b_stray_update: got %0d want %0d", stray, s0); end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL final_ferr_count: got %0d want %0d", ferr_cnt, exp_ferr); end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_frame_error();
    test_glitch();
    test_timeout();
    test_reset_mid_byte();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
